// File: rtl/y86_fetch_unit.sv
// Multicycle byte-serial Y86-64 fetch stage: PC owner, instruction splitter, valid/ready to decode.
// Optional FETCH_TIMEOUT_EN: a byte read that waits TIMEOUT_CYCLES cycles aborts as an address fault.
module y86_fetch_unit #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  input  logic        pc_load,
  input  logic [63:0] new_pc
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_REGS,
    S_CONST,
    S_DONE,
    S_HALTED
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [2:0]  cidx;
  logic        tmo_c;
  logic        take_c;
  logic        abort_c;
  logic [63:0] nxt_pc_c;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      4'h7, 4'h8:             instr_len = 4'd9;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  function automatic logic has_const(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
      default:                      has_const = 1'b0;
    endcase
  endfunction

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wait_cnt;

  // Per-byte wait counter; any ack or idle cycle clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ack && !tmo_c) begin
      wait_cnt <= wait_cnt + TCW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign tmo_c = mem_req && !mem_ack && (wait_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
  // No timeout: the unit waits for an ack indefinitely.
  assign tmo_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  assign take_c   = mem_req && (mem_ack || tmo_c);
  assign abort_c  = (mem_ack && mem_err) || tmo_c;
  assign nxt_pc_c = pc_load ? new_pc : valP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH0;
      pc        <= RESET_PC;
      cidx      <= 3'd0;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      out_valid <= 1'b0;
      icode     <= 4'h0;
      ifun      <= 4'h0;
      rA        <= RNONE;
      rB        <= RNONE;
      valC      <= 64'h0;
      valP      <= 64'h0;
      stat      <= STAT_AOK;
    end else begin
      case (state)
        S_FETCH0: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (take_c) begin
            mem_addr <= mem_addr + 64'd1;
            icode    <= mem_rdata[7:4];
            ifun     <= mem_rdata[3:0];
            valP     <= pc + 64'(instr_len(mem_rdata[7:4]));
            if (abort_c || mem_rdata[7:4] >= 4'hC || mem_rdata[7:4] == 4'h0 ||
                instr_len(mem_rdata[7:4]) == 4'd1) begin
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
              if (abort_c)                    stat <= STAT_ADR;
              else if (mem_rdata[7:4] >= 4'hC) stat <= STAT_INS;
              else if (mem_rdata[7:4] == 4'h0) stat <= STAT_HLT;
            end else if (has_regs(mem_rdata[7:4])) begin
              state <= S_REGS;
            end else begin
              cidx  <= 3'd0;
              state <= S_CONST;
            end
          end
        end
        S_REGS: begin
          if (take_c) begin
            mem_addr <= mem_addr + 64'd1;
            if (abort_c) begin
              stat      <= STAT_ADR;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              rA <= mem_rdata[7:4];
              rB <= mem_rdata[3:0];
              if (has_const(icode)) begin
                cidx  <= 3'd0;
                state <= S_CONST;
              end else begin
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                state     <= S_DONE;
              end
            end
          end
        end
        S_CONST: begin
          // Little-endian constant: byte k lands in valC[8k+7:8k].
          if (take_c) begin
            mem_addr <= mem_addr + 64'd1;
            if (abort_c) begin
              stat      <= STAT_ADR;
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              valC[{cidx, 3'b000} +: 8] <= mem_rdata;
              if (cidx == 3'd7) begin
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                cidx <= cidx + 3'd1;
              end
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc        <= nxt_pc_c;
            if (stat != STAT_AOK || icode == 4'h0) begin
              state <= S_HALTED;
            end else begin
              state    <= S_FETCH0;
              mem_req  <= 1'b1;
              mem_addr <= nxt_pc_c;
              rA       <= RNONE;
              rB       <= RNONE;
              valC     <= 64'h0;
            end
          end
        end
        S_HALTED: begin
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit with a zero-wait byte memory responder.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;
  logic        pc_load = 1'b0;
  logic [63:0] new_pc = 64'h0;

  logic [7:0]  mem [0:511];
  logic        ack_en = 1'b1;
  logic        err_en = 1'b0;
  logic        force_ack = 1'b0;
  logic [63:0] err_addr = 64'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:0]];
  assign mem_ack   = (mem_req && ack_en) || force_ack;
  assign mem_err   = err_en && (mem_addr == err_addr);

  y86_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat),
    .pc_load(pc_load), .new_pc(new_pc)
  );

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    pc_load = 1'b0;
    ack_en = 1'b1;
    err_en = 1'b0;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake(input logic ld, input logic [63:0] tgt);
    out_ready = 1'b1;
    pc_load = ld;
    new_pc = tgt;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({mem_req, out_valid, icode, ifun, rA, rB, valC, valP, stat} !==
        {1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1}) begin
      bad++;
      $display("FAIL reset_values got req=%b v=%b ic=%h if=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
               mem_req, out_valid, icode, ifun, rA, rB, valC, valP, stat);
    end
    clear_mem();
    mem[0] = 8'h10;
    do_reset();
    @(posedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
      bad++;
      $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_irmovq();
    logic [7:0] prog [0:9] = '{8'h30, 8'hF3, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    int cyc;
    bit ok;
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = prog[i];
    do_reset();
    wait_valid(40, cyc, ok);
    total++;
    if (!ok || cyc != 11) begin
      bad++;
      $display("FAIL irmovq_latency got ok=%b cycle=%0d exp cycle=11", ok, cyc);
    end
    total++;
    if ({icode, ifun, rA, rB} !== 16'h30F3) begin
      bad++;
      $display("FAIL irmovq_fields got %h exp 30f3", {icode, ifun, rA, rB});
    end
    total++;
    if (valC !== 64'h123456789ABCDEF0 || valP !== 64'h0A || stat !== 3'd1) begin
      bad++;
      $display("FAIL irmovq_vals got valC=%h valP=%h stat=%0d exp 123456789abcdef0/a/1", valC, valP, stat);
    end
  endtask

  task automatic test_sequence();
    logic [63:0] exp_valp [0:2] = '{64'd1, 64'd3, 64'd4};
    logic [2:0]  exp_stat [0:2] = '{3'd1, 3'd1, 3'd2};
    logic [3:0]  exp_ic   [0:2] = '{4'h1, 4'h6, 4'h0};
    logic [7:0]  exp_regs [0:2] = '{8'hFF, 8'h23, 8'hFF};
    int cyc;
    bit ok;
    bit quiet;
    clear_mem();
    mem[0] = 8'h10;
    mem[1] = 8'h60;
    mem[2] = 8'h23;
    mem[3] = 8'h00;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_valid(20, cyc, ok);
      total++;
      if (!ok || valP !== exp_valp[k] || stat !== exp_stat[k] || icode !== exp_ic[k] ||
          {rA, rB} !== exp_regs[k]) begin
        bad++;
        $display("FAIL seq_instr%0d got ok=%b ic=%h regs=%h valP=%h stat=%0d exp ic=%h regs=%h valP=%h stat=%0d",
                 k, ok, icode, {rA, rB}, valP, stat, exp_ic[k], exp_regs[k], exp_valp[k], exp_stat[k]);
      end
      handshake(1'b0, 64'h0);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mem_req !== 1'b0 || out_valid !== 1'b0) quiet = 1'b0;
      @(posedge clk);
      #1;
    end
    total++;
    if (!quiet || stat !== 3'd2) begin
      bad++;
      $display("FAIL halt_quiet got quiet=%b stat=%0d exp quiet=1 stat=2", quiet, stat);
    end
  endtask

  task automatic test_call_redirect();
    int cyc;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = 8'h10;
      mem[32] = 8'h80;
      mem[33] = 8'h00;
      mem[34] = 8'h01;
      do_reset();
      wait_valid(20, cyc, ok);
      handshake(1'b1, 64'h20);
      total++;
      if (!ok || mem_addr !== 64'h20 || mem_req !== 1'b1) begin
        bad++;
        $display("FAIL redirect_0x20 got ok=%b addr=%h req=%b exp addr=20 req=1", ok, mem_addr, mem_req);
      end
      wait_valid(20, cyc, ok);
      total++;
      if (!ok || icode !== 4'h8 || rA !== 4'hF || valC !== 64'h100 || valP !== 64'h29 || stat !== 3'd1) begin
        bad++;
        $display("FAIL call_fields got ok=%b ic=%h rA=%h valC=%h valP=%h stat=%0d exp 8/f/100/29/1",
                 ok, icode, rA, valC, valP, stat);
      end
      handshake(pass == 0, 64'h100);
      total++;
      if (mem_addr !== (pass == 0 ? 64'h100 : 64'h29)) begin
        bad++;
        $display("FAIL call_next_pc pass%0d got %h exp %h", pass, mem_addr, (pass == 0 ? 64'h100 : 64'h29));
      end
    end
  endtask

  task automatic test_invalid();
    int cyc;
    bit ok;
    bit quiet;
    clear_mem();
    mem[0] = 8'hF0;
    do_reset();
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || stat !== 3'd4 || valP !== 64'h1 || icode !== 4'hF) begin
      bad++;
      $display("FAIL invalid_ins got ok=%b stat=%0d valP=%h ic=%h exp stat=4 valP=1 ic=f", ok, stat, valP, icode);
    end
    handshake(1'b0, 64'h0);
    force_ack = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b0 || out_valid !== 1'b0 || stat !== 3'd4) quiet = 1'b0;
    end
    force_ack = 1'b0;
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL invalid_halted got req=%b valid=%b stat=%0d exp 0/0/4", mem_req, out_valid, stat);
    end
  endtask

  task automatic test_mem_err();
    int cyc;
    bit ok;
    bit quiet;
    clear_mem();
    mem[0] = 8'h50;
    mem[1] = 8'h12;
    do_reset();
    err_en = 1'b1;
    err_addr = 64'h3;
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || cyc != 5 || stat !== 3'd3 || valP !== 64'h0A) begin
      bad++;
      $display("FAIL mem_err got ok=%b cycle=%0d stat=%0d valP=%h exp cycle=5 stat=3 valP=a", ok, cyc, stat, valP);
    end
    handshake(1'b0, 64'h0);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL mem_err_no_req got req=%b exp 0", mem_req);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    clear_mem();
    mem[0] = 8'h60;
    mem[1] = 8'h23;
    do_reset();
    wait_valid(20, cyc, ok);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!ok || out_valid !== 1'b1 || mem_req !== 1'b0 ||
          {icode, ifun, rA, rB} !== 16'h6023 || valC !== 64'h0 || valP !== 64'h2 || stat !== 3'd1) begin
        bad++;
        $display("FAIL hold_cycle%0d got v=%b req=%b f=%h valC=%h valP=%h stat=%0d exp 1/0/6023/0/2/1",
                 i, out_valid, mem_req, {icode, ifun, rA, rB}, valC, valP, stat);
      end
      @(posedge clk);
      #1;
    end
    handshake(1'b0, 64'h0);
    total++;
    if (out_valid !== 1'b0 || mem_addr !== 64'h2 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got v=%b addr=%h req=%b exp 0/2/1", out_valid, mem_addr, mem_req);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] prog [0:9] = '{8'h30, 8'hF3, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = prog[i];
    do_reset();
    repeat (6) @(posedge clk);
    #2;
    total++;
    if (valC[15:0] !== 16'hDEF0) begin
      bad++;
      $display("FAIL mid_const_progress got valC=%h exp low 16 bits def0", valC);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({mem_req, out_valid, icode, ifun, rA, rB, valC, valP, stat} !==
        {1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1}) begin
      bad++;
      $display("FAIL reset_mid got req=%b v=%b ic=%h rA=%h rB=%h valC=%h stat=%0d",
               mem_req, out_valid, icode, rA, rB, valC, stat);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_wait();
    int cyc;
    bit ok;
    clear_mem();
    mem[0] = 8'h10;
    do_reset();
    ack_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_valid(30, cyc, ok);
    total++;
    if (!ok || cyc != 5 || stat !== 3'd3) begin
      bad++;
      $display("FAIL timeout got ok=%b cycle=%0d stat=%0d exp cycle=5 stat=3", ok, cyc, stat);
    end
`else
    wait_valid(100, cyc, ok);
    total++;
    if (ok || mem_req !== 1'b1 || mem_addr !== 64'h0 || stat !== 3'd1) begin
      bad++;
      $display("FAIL no_timeout got valid=%b req=%b addr=%h stat=%0d exp 0/1/0/1", ok, mem_req, mem_addr, stat);
    end
`endif
    ack_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_sequence();
    test_call_redirect();
    test_invalid();
    test_mem_err();
    test_backpressure();
    test_reset_mid();
    test_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
